// File: rtl/lookup_map_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lookup_map_bank_ctrl_pkg
//   Shared definitions for the Y lookup-map bank controller: the DI terminal
//   id of this block and the controller FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package lookup_map_bank_ctrl_pkg;

   // DI register terminal id of the lookup map bank controller.
   localparam logic [7:0] TERM_LOOKUP_MAP_BANK = 8'h2c;

   // INIT    : both banks are filled with the identity ramp, one entry a cycle
   // IDLE    : normal operation, shadow bank open to DI
   // PENDING : a commit was accepted; waiting for the next frame_start
   // SWAP    : one cycle in which the banks have just changed roles
   typedef enum logic [1:0] {
      LMB_INIT    = 2'd0,
      LMB_IDLE    = 2'd1,
      LMB_PENDING = 2'd2,
      LMB_SWAP    = 2'd3
   } lmb_state_t;

endpackage

// File: rtl/lookup_map_bank_ctrl_rowbuffer.sv
// -----------------------------------------------------------------------------
// lookup_map_bank_ctrl_rowbuffer
//   Single-port synchronous RAM holding one LUT bank. The read is registered
//   and returns the contents before a write to the same address in that cycle.
// Ports
//   pixclk  in   clock
//   we      in   write enable
//   addr    in   ADDR_WIDTH   read/write address
//   wdata   in   PIXEL_WIDTH  write data
//   rdata   out  PIXEL_WIDTH  registered read data (one cycle after addr)
// -----------------------------------------------------------------------------
module lookup_map_bank_ctrl_rowbuffer #(
   parameter int ADDR_WIDTH  = 10,
   parameter int PIXEL_WIDTH = 8,
   parameter int MAX_COLS    = 2**ADDR_WIDTH
) (
   input  logic                   pixclk,
   input  logic                   we,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [PIXEL_WIDTH-1:0] wdata,
   output logic [PIXEL_WIDTH-1:0] rdata
);

   logic [PIXEL_WIDTH-1:0] mem [MAX_COLS];

   always_ff @(posedge pixclk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/lookup_map_bank_ctrl.sv
// -----------------------------------------------------------------------------
// lookup_map_bank_ctrl
//   Ping-pong controller for the Y lookup table. One bank (active) serves the
//   pixel path, the other (shadow) is loaded over DI. After reset both banks
//   are filled with an identity ramp. A DI commit arms a swap that happens at
//   the next frame_start, so a frame never sees a half-updated table.
// Ports
//   pixclk        in   clock
//   resetb        in   synchronous active-low reset
//   enable        in   1: yo = LUT[yi], 0: yo = yi (same latency)
//   frame_start   in   strobe on first pixel of a frame
//   commit        in   strobe: swap banks at next frame_start
//   di_write      in   write di_datai to shadow[di_addr]
//   di_read_req   in   read shadow[di_addr]
//   di_addr       in   shadow bank address
//   di_datai      in   write data, low PIXEL_WIDTH bits stored
//   di_datao      out  read data, zero-extended
//   di_read_rdy   out  di_datao valid (2 cycles after di_read_req)
//   di_write_rdy  out  shadow accepts writes (IDLE / PENDING)
//   busy          out  INIT fill in progress
//   pending       out  commit accepted, swap not done yet
//   active_bank   out  bank feeding pixel reads
//   dvi / yi      in   input pixel valid / luma
//   dvo / yo      out  output valid / luma, 2-cycle latency, yo=0 when !dvo
//   fsm_state     out  controller state, for observation
// -----------------------------------------------------------------------------
module lookup_map_bank_ctrl
   import lookup_map_bank_ctrl_pkg::*;
#(
   parameter int PIXEL_WIDTH   = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int DI_DATA_WIDTH = 16
) (
   input  logic                     pixclk,
   input  logic                     resetb,
   input  logic                     enable,
   input  logic                     frame_start,
   input  logic                     commit,
   input  logic                     di_write,
   input  logic                     di_read_req,
   input  logic [ADDR_WIDTH-1:0]    di_addr,
   input  logic [DI_DATA_WIDTH-1:0] di_datai,
   output logic [DI_DATA_WIDTH-1:0] di_datao,
   output logic                     di_read_rdy,
   output logic                     di_write_rdy,
   output logic                     busy,
   output logic                     pending,
   output logic                     active_bank,
   input  logic                     dvi,
   input  logic [PIXEL_WIDTH-1:0]   yi,
   output logic                     dvo,
   output logic [PIXEL_WIDTH-1:0]   yo,
   output lmb_state_t               fsm_state
);

   localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'((2**ADDR_WIDTH) - 1);

   lmb_state_t              state;
   lmb_state_t              state_nxt;
   logic [ADDR_WIDTH-1:0]   fill_cnt;
   logic                    in_init;
   logic                    swap_now;
   logic                    read_bank;

   logic [1:0]              bank_we;
   logic [ADDR_WIDTH-1:0]   bank_addr  [2];
   logic [PIXEL_WIDTH-1:0]  bank_wdata [2];
   logic [PIXEL_WIDTH-1:0]  bank_rdata [2];

   // Stage 1 of the pixel and DI read pipelines (RAM read in flight).
   logic                    pix_dv_d1;
   logic [PIXEL_WIDTH-1:0]  pix_y_d1;
   logic                    pix_map_d1;
   logic                    pix_bank_d1;
   logic                    rd_req_d1;
   logic                    rd_zero_d1;
   logic                    rd_bank_d1;

   logic                    di_datai_unused;
   assign di_datai_unused = ^di_datai[DI_DATA_WIDTH-1:PIXEL_WIDTH];

   assign in_init      = (state == LMB_INIT);
   assign busy         = in_init;
   assign pending      = (state == LMB_PENDING);
   assign di_write_rdy = (state == LMB_IDLE) || (state == LMB_PENDING);
   assign fsm_state    = state;

   // The frame_start pixel must already read the new table, but the state
   // only reaches SWAP one cycle later. So the register active_bank flips on
   // the edge into SWAP, and for the frame_start cycle itself the read bank
   // is the flipped value combinationally.
   assign swap_now  = (state == LMB_PENDING) && frame_start;
   assign read_bank = active_bank ^ swap_now;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge pixclk) begin
      if (!resetb) begin
         state       <= LMB_INIT;
         fill_cnt    <= '0;
         active_bank <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_init) begin
            fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
         end
         if (swap_now) begin
            active_bank <= ~active_bank;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LMB_INIT:    if (fill_cnt == FILL_LAST) state_nxt = LMB_IDLE;
         LMB_IDLE:    if (commit) state_nxt = LMB_PENDING;
         // A second commit while pending is absorbed: still one swap.
         LMB_PENDING: if (frame_start) state_nxt = LMB_SWAP;
         // A commit arriving in the swap cycle arms the next swap.
         LMB_SWAP:    state_nxt = commit ? LMB_PENDING : LMB_IDLE;
         default:     state_nxt = LMB_INIT;
      endcase
   end

   // ------------------------------------------------ per-bank address/we mux
   // INIT writes both banks at once. Entry a holds a truncated to
   // PIXEL_WIDTH, so a zero-extended yi looks up exactly yi.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         bank_we[b]    = 1'b0;
         bank_addr[b]  = di_addr;
         bank_wdata[b] = di_datai[PIXEL_WIDTH-1:0];
         if (in_init) begin
            bank_we[b]    = 1'b1;
            bank_addr[b]  = fill_cnt;
            bank_wdata[b] = fill_cnt[PIXEL_WIDTH-1:0];
         end else if (1'(b) == read_bank) begin
            bank_addr[b]  = ADDR_WIDTH'(yi);
         end else begin
            bank_we[b]    = di_write && di_write_rdy;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      lookup_map_bank_ctrl_rowbuffer #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .PIXEL_WIDTH (PIXEL_WIDTH),
         .MAX_COLS    (2**ADDR_WIDTH)
      ) u_rowbuffer (
         .pixclk (pixclk),
         .we     (bank_we[g]),
         .addr   (bank_addr[g]),
         .wdata  (bank_wdata[g]),
         .rdata  (bank_rdata[g])
      );
   end

   // ------------------------------------------- pixel and DI read pipelines
   always_ff @(posedge pixclk) begin
      if (!resetb) begin
         pix_dv_d1   <= 1'b0;
         pix_y_d1    <= '0;
         pix_map_d1  <= 1'b0;
         pix_bank_d1 <= 1'b0;
         rd_req_d1   <= 1'b0;
         rd_zero_d1  <= 1'b0;
         rd_bank_d1  <= 1'b0;
         dvo         <= 1'b0;
         yo          <= '0;
         di_read_rdy <= 1'b0;
         di_datao    <= '0;
      end else begin
         pix_dv_d1   <= dvi;
         pix_y_d1    <= yi;
         // INIT forces bypass; the banks are not readable yet.
         pix_map_d1  <= enable && !in_init;
         pix_bank_d1 <= read_bank;
         rd_req_d1   <= di_read_req;
         rd_zero_d1  <= in_init;
         rd_bank_d1  <= ~read_bank;

         dvo <= pix_dv_d1;
         if (!pix_dv_d1) begin
            yo <= '0;
         end else if (pix_map_d1) begin
            yo <= bank_rdata[pix_bank_d1];
         end else begin
            yo <= pix_y_d1;
         end

         di_read_rdy <= rd_req_d1;
         if (rd_req_d1 && !rd_zero_d1) begin
            di_datao <= DI_DATA_WIDTH'(bank_rdata[rd_bank_d1]);
         end else begin
            di_datao <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lookup_map_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lookup_map_bank_ctrl
//   Bench for lookup_map_bank_ctrl. A reference model holds both LUT banks as
//   plain arrays plus "active bank", "swap armed" and "fill cycles left";
//   each clock cycle it predicts the pixel and DI read results, which travel
//   through expected queues to meet the 2-cycle latency of the design.
// -----------------------------------------------------------------------------
module tb_lookup_map_bank_ctrl;
   import lookup_map_bank_ctrl_pkg::*;

   localparam int PW    = 8;
   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 2**AW;

   // ------------------------------------------------------ clock and reset
   logic pixclk = 1'b0;
   always #5 pixclk = ~pixclk;

   logic          resetb = 1'b0;
   logic          enable = 1'b1;
   logic          frame_start = 1'b0;
   logic          commit = 1'b0;
   logic          di_write = 1'b0;
   logic          di_read_req = 1'b0;
   logic [AW-1:0] di_addr = '0;
   logic [DW-1:0] di_datai = '0;
   logic [DW-1:0] di_datao;
   logic          di_read_rdy;
   logic          di_write_rdy;
   logic          busy;
   logic          pending;
   logic          active_bank;
   logic          dvi = 1'b0;
   logic [PW-1:0] yi = '0;
   logic          dvo;
   logic [PW-1:0] yo;
   lmb_state_t    fsm_state;

   lookup_map_bank_ctrl #(
      .PIXEL_WIDTH   (PW),
      .ADDR_WIDTH    (AW),
      .DI_DATA_WIDTH (DW)
   ) dut (
      .pixclk       (pixclk),
      .resetb       (resetb),
      .enable       (enable),
      .frame_start  (frame_start),
      .commit       (commit),
      .di_write     (di_write),
      .di_read_req  (di_read_req),
      .di_addr      (di_addr),
      .di_datai     (di_datai),
      .di_datao     (di_datao),
      .di_read_rdy  (di_read_rdy),
      .di_write_rdy (di_write_rdy),
      .busy         (busy),
      .pending      (pending),
      .active_bank  (active_bank),
      .dvi          (dvi),
      .yi           (yi),
      .dvo          (dvo),
      .yo           (yo),
      .fsm_state    (fsm_state)
   );

   int errors = 0;
   int checks = 0;

   // ------------------------------------------------------ reference model
   logic [PW-1:0] mdl_lut [2][DEPTH];
   int            mdl_active;
   bit            mdl_pending;
   int            mdl_init_left;
   bit            mdl_swap;     // the coming cycle is the swap cycle
   logic [PW:0]   exp_pix_q [$];  // {dvo, yo}
   logic [DW:0]   exp_rd_q  [$];  // {di_read_rdy, di_datao}
   logic          due_dvo;
   logic [PW-1:0] due_yo;
   logic          due_rdy;
   logic [DW-1:0] due_dat;

   function automatic void mdl_reset();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < DEPTH; a++)
            mdl_lut[b][a] = PW'(a);
      mdl_active    = 0;
      mdl_pending   = 0;
      mdl_init_left = DEPTH;
      mdl_swap      = 0;
      exp_pix_q.delete();
      exp_rd_q.delete();
      exp_pix_q.push_back('0);
      exp_rd_q.push_back('0);
   endfunction

   // ------------------------------------------------------ driver
   // Applies the current inputs for one clock, advances the model and leaves
   // the values the outputs must show now in due_*.
   task automatic drive_cycle();
      logic [PW:0] ep;
      logic [DW:0] er;
      bit          in_swap;
      bit          swapping;
      if (!resetb) begin
         @(posedge pixclk); #1;
         mdl_reset();
         due_dvo = 0; due_yo = 0; due_rdy = 0; due_dat = 0;
      end else begin
         in_swap  = mdl_swap;
         mdl_swap = 0;
         if (mdl_init_left > 0) begin
            ep = dvi ? {1'b1, yi} : '0;
            er = di_read_req ? {1'b1, {DW{1'b0}}} : '0;
            mdl_init_left--;
         end else begin
            swapping = mdl_pending && frame_start;
            if (swapping) begin
               mdl_active  = 1 - mdl_active;
               mdl_pending = 0;
               mdl_swap    = 1;
            end
            ep = !dvi ? '0 : {1'b1, (enable ? mdl_lut[mdl_active][yi] : yi)};
            er = !di_read_req ? '0 : {1'b1, DW'(mdl_lut[1-mdl_active][di_addr])};
            if (di_write && !in_swap)
               mdl_lut[1-mdl_active][di_addr] = di_datai[PW-1:0];
            if (commit && !mdl_pending && !swapping)
               mdl_pending = 1;
         end
         exp_pix_q.push_back(ep);
         exp_rd_q.push_back(er);
         @(posedge pixclk); #1;
         ep = exp_pix_q.pop_front();
         er = exp_rd_q.pop_front();
         due_dvo = ep[PW]; due_yo = ep[PW-1:0];
         due_rdy = er[DW]; due_dat = er[DW-1:0];
      end
   endtask

   task automatic quiet_inputs();
      frame_start = 0; commit = 0; di_write = 0; di_read_req = 0;
   endtask

   task automatic random_pixel();
      dvi = ($urandom_range(0, 3) != 0);
      yi  = PW'($urandom_range(0, 255));
   endtask

   // ------------------------------------------------------ tests
   task automatic test_reset();
      int n;
      quiet_inputs();
      enable = 1;
      resetb = 0;
      repeat (4) begin
         random_pixel();
         drive_cycle();
      end
      checks++;
      if ({busy, di_write_rdy, pending, active_bank} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags: busy/wrdy/pend/bank got %b want 1000",
                  {busy, di_write_rdy, pending, active_bank});
      end
      checks++;
      if ({dvo, yo, di_read_rdy, di_datao} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: dvo=%0b yo=%0d rdy=%0b dat=%0d want all 0",
                  dvo, yo, di_read_rdy, di_datao);
      end
      checks++;
      if (fsm_state !== LMB_INIT) begin
         errors++;
         $display("FAIL reset_state: got %0d want %0d", fsm_state, LMB_INIT);
      end
      resetb = 1;
      n = 0;
      while (n < 1100) begin
         random_pixel();
         drive_cycle();
         n++;
         checks++;
         if ({dvo, yo} !== {due_dvo, due_yo}) begin
            errors++;
            $display("FAIL init_bypass: dvo/yo got %0b/%0d want %0b/%0d", dvo, yo, due_dvo, due_yo);
         end
         if (!busy) break;
      end
      checks++;
      if (n !== 1024) begin
         errors++;
         $display("FAIL init_length: busy fell after %0d cycles want 1024", n);
      end
      checks++;
      if (di_write_rdy !== 1'b1) begin
         errors++;
         $display("FAIL init_done_wrdy: got %0b want 1", di_write_rdy);
      end
   endtask

   task automatic test_identity();
      enable = 1;
      quiet_inputs();
      for (int y = 0; y < 258; y++) begin
         dvi = (y < 256) && ($urandom_range(0, 3) != 0);
         yi  = PW'(y);
         drive_cycle();
         checks++;
         if ({dvo, yo} !== {due_dvo, due_yo}) begin
            errors++;
            $display("FAIL identity_pix: y=%0d dvo/yo got %0b/%0d want %0b/%0d",
                     y, dvo, yo, due_dvo, due_yo);
         end
      end
   endtask

   task automatic test_di_write_read();
      enable = 1;
      quiet_inputs();
      for (int a = 0; a < 256; a++) begin
         checks++;
         if (di_write_rdy !== 1'b1) begin
            errors++;
            $display("FAIL di_wrdy_idle: got %0b want 1", di_write_rdy);
         end
         di_write = 1;
         di_addr  = AW'(a);
         di_datai = {8'($urandom_range(0, 255)), 8'(255 - a)};
         random_pixel();
         drive_cycle();
         checks++;
         if ({dvo, yo} !== {due_dvo, due_yo}) begin
            errors++;
            $display("FAIL load_pix: dvo/yo got %0b/%0d want %0b/%0d", dvo, yo, due_dvo, due_yo);
         end
      end
      di_write = 0;
      // Read back address 7: ready and data exactly two cycles later.
      di_read_req = 1; di_addr = 7;
      drive_cycle();
      di_read_req = 0;
      checks++;
      if (di_read_rdy !== 1'b0) begin
         errors++;
         $display("FAIL read_early: rdy got %0b want 0 one cycle after request", di_read_rdy);
      end
      drive_cycle();
      checks++;
      if ({di_read_rdy, di_datao} !== {1'b1, 16'd248}) begin
         errors++;
         $display("FAIL read_a7: rdy/data got %0b/%0d want 1/248", di_read_rdy, di_datao);
      end
      drive_cycle();
      checks++;
      if (di_read_rdy !== 1'b0) begin
         errors++;
         $display("FAIL read_late: rdy got %0b want 0", di_read_rdy);
      end
      // Back-to-back random reads over the whole address range.
      for (int i = 0; i < 30; i++) begin
         di_read_req = (i < 28);
         di_addr     = AW'($urandom_range(0, DEPTH - 1));
         random_pixel();
         drive_cycle();
         checks++;
         if ({di_read_rdy, di_datao, dvo, yo} !== {due_rdy, due_dat, due_dvo, due_yo}) begin
            errors++;
            $display("FAIL read_rand: rdy/dat/dvo/yo got %0b/%0d/%0b/%0d want %0b/%0d/%0b/%0d",
                     di_read_rdy, di_datao, dvo, yo, due_rdy, due_dat, due_dvo, due_yo);
         end
      end
      di_read_req = 0;
   endtask

   task automatic test_commit_swap();
      enable = 1;
      quiet_inputs();
      commit = 1;
      random_pixel();
      drive_cycle();
      commit = 0;
      for (int i = 0; i < 10; i++) begin
         random_pixel();
         drive_cycle();
         checks++;
         if ({pending, active_bank} !== 2'b10) begin
            errors++;
            $display("FAIL pending_hold: pend/bank got %0b/%0b want 1/0", pending, active_bank);
         end
      end
      frame_start = 1; dvi = 1; yi = 10;
      drive_cycle();
      frame_start = 0;
      checks++;
      if ({pending, active_bank, di_write_rdy} !== 3'b010) begin
         errors++;
         $display("FAIL swap_cycle: pend/bank/wrdy got %0b/%0b/%0b want 0/1/0",
                  pending, active_bank, di_write_rdy);
      end
      // Write during the swap cycle must be dropped.
      di_write = 1; di_addr = 5; di_datai = 16'h0077;
      dvi = 1; yi = 0;
      drive_cycle();
      di_write = 0;
      checks++;
      if ({dvo, yo} !== {1'b1, 8'd245}) begin
         errors++;
         $display("FAIL swap_first_pix: dvo/yo got %0b/%0d want 1/245", dvo, yo);
      end
      di_read_req = 1; di_addr = 5; dvi = 0;
      drive_cycle();
      di_read_req = 0;
      checks++;
      if ({dvo, yo} !== {1'b1, 8'd255}) begin
         errors++;
         $display("FAIL swap_second_pix: dvo/yo got %0b/%0d want 1/255", dvo, yo);
      end
      drive_cycle();
      checks++;
      if ({di_read_rdy, di_datao} !== {1'b1, 16'd5}) begin
         errors++;
         $display("FAIL swap_write_drop: rdy/data got %0b/%0d want 1/5", di_read_rdy, di_datao);
      end
   endtask

   task automatic test_back_to_back();
      int start_bank;
      enable = 1;
      quiet_inputs();
      start_bank = mdl_active;
      // commit together with frame_start in IDLE: armed, no swap this frame.
      commit = 1; frame_start = 1; random_pixel();
      drive_cycle();
      commit = 0; frame_start = 0;
      checks++;
      if ({pending, active_bank} !== {1'b1, 1'(start_bank)}) begin
         errors++;
         $display("FAIL same_cycle_commit: pend/bank got %0b/%0b want 1/%0d", pending, active_bank, start_bank);
      end
      repeat (5) begin random_pixel(); drive_cycle(); end
      frame_start = 1; random_pixel();
      drive_cycle();
      frame_start = 0;
      checks++;
      if ({pending, active_bank} !== {1'b0, 1'(1 - start_bank)}) begin
         errors++;
         $display("FAIL next_frame_swap: pend/bank got %0b/%0b want 0/%0d", pending, active_bank, 1 - start_bank);
      end
      // Two commits before the frame boundary still give exactly one swap.
      repeat (3) begin random_pixel(); drive_cycle(); end
      commit = 1; drive_cycle(); commit = 0;
      repeat (2) begin random_pixel(); drive_cycle(); end
      commit = 1; drive_cycle(); commit = 0;
      frame_start = 1; random_pixel(); drive_cycle(); frame_start = 0;
      repeat (3) begin random_pixel(); drive_cycle(); end
      frame_start = 1; random_pixel(); drive_cycle(); frame_start = 0;
      checks++;
      if ({pending, active_bank} !== {1'b0, 1'(start_bank)}) begin
         errors++;
         $display("FAIL double_commit: pend/bank got %0b/%0b want 0/%0d", pending, active_bank, start_bank);
      end
      // Commit in the swap cycle re-arms.
      commit = 1; drive_cycle(); commit = 0;
      frame_start = 1; random_pixel(); drive_cycle(); frame_start = 0;
      commit = 1; random_pixel(); drive_cycle(); commit = 0;
      checks++;
      if ({pending, active_bank} !== {1'b1, 1'(1 - start_bank)}) begin
         errors++;
         $display("FAIL swap_cycle_commit: pend/bank got %0b/%0b want 1/%0d", pending, active_bank, 1 - start_bank);
      end
      frame_start = 1; random_pixel(); drive_cycle(); frame_start = 0;
      for (int i = 0; i < 4; i++) begin
         random_pixel();
         drive_cycle();
         checks++;
         if ({dvo, yo, active_bank} !== {due_dvo, due_yo, 1'(mdl_active)}) begin
            errors++;
            $display("FAIL b2b_pix: dvo/yo/bank got %0b/%0d/%0b want %0b/%0d/%0d",
                     dvo, yo, active_bank, due_dvo, due_yo, mdl_active);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         enable      = ($urandom_range(0, 9) != 0);
         frame_start = ($urandom_range(0, 39) == 0);
         commit      = ($urandom_range(0, 59) == 0);
         di_write    = ($urandom_range(0, 3) == 0);
         di_read_req = ($urandom_range(0, 3) == 0);
         di_addr     = AW'($urandom_range(0, DEPTH - 1));
         di_datai    = DW'($urandom_range(0, 65535));
         random_pixel();
         drive_cycle();
         checks++;
         if ({dvo, yo} !== {due_dvo, due_yo}) begin
            errors++;
            $display("FAIL rand_pix: dvo/yo got %0b/%0d want %0b/%0d", dvo, yo, due_dvo, due_yo);
         end
         checks++;
         if ({di_read_rdy, di_datao} !== {due_rdy, due_dat}) begin
            errors++;
            $display("FAIL rand_read: rdy/data got %0b/%0d want %0b/%0d", di_read_rdy, di_datao, due_rdy, due_dat);
         end
         checks++;
         if ({pending, active_bank, di_write_rdy, busy} !==
             {mdl_pending, 1'(mdl_active), !mdl_swap, 1'b0}) begin
            errors++;
            $display("FAIL rand_ctrl: pend/bank/wrdy/busy got %0b/%0b/%0b/%0b want %0b/%0d/%0b/0",
                     pending, active_bank, di_write_rdy, busy, mdl_pending, mdl_active, !mdl_swap);
         end
      end
      quiet_inputs();
      enable = 1;
   endtask

   task automatic test_reset_mid();
      int n;
      quiet_inputs();
      enable = 1;
      // Make sure bank 1 is active so the reset visibly returns it to 0.
      if (mdl_pending) begin
         frame_start = 1; drive_cycle(); frame_start = 0; drive_cycle();
      end
      if (mdl_active == 0) begin
         commit = 1; drive_cycle(); commit = 0;
         frame_start = 1; drive_cycle(); frame_start = 0; drive_cycle();
      end
      commit = 1; drive_cycle(); commit = 0;
      checks++;
      if ({pending, active_bank} !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset: pend/bank got %0b/%0b want 1/1", pending, active_bank);
      end
      resetb = 0;
      repeat (2) drive_cycle();
      checks++;
      if ({pending, active_bank, busy} !== 3'b001) begin
         errors++;
         $display("FAIL mid_reset: pend/bank/busy got %0b/%0b/%0b want 0/0/1", pending, active_bank, busy);
      end
      resetb = 1;
      n = 0;
      while (n < 1100) begin
         random_pixel();
         drive_cycle();
         n++;
         if (!busy) break;
      end
      checks++;
      if (n !== 1024) begin
         errors++;
         $display("FAIL reinit_length: busy fell after %0d cycles want 1024", n);
      end
      for (int y = 0; y < 258; y++) begin
         dvi = (y < 256);
         yi  = PW'(y);
         drive_cycle();
         checks++;
         if ({dvo, yo} !== {due_dvo, due_yo}) begin
            errors++;
            $display("FAIL reinit_identity: dvo/yo got %0b/%0d want %0b/%0d", dvo, yo, due_dvo, due_yo);
         end
      end
      // A frame_start after the reset must not swap: the commit was discarded.
      frame_start = 1; drive_cycle(); frame_start = 0;
      checks++;
      if ({pending, active_bank} !== 2'b00) begin
         errors++;
         $display("FAIL commit_discarded: pend/bank got %0b/%0b want 0/0", pending, active_bank);
      end
   endtask

   // ------------------------------------------------------ sequence + report
   initial begin
      mdl_reset();
      test_reset();
      test_identity();
      test_di_write_read();
      test_commit_swap();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
